// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the clock-enable divider.
// Holds the active divide factor, sequences the divide counter and produces
// a divided enable (clk_en) plus a period-start tick. New factors arrive on
// a valid/ready handshake. While running they are applied only at a period
// boundary, so clk_en never shows a runt or stretched period.
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_en,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO  = '0;

    // Registered state
    state_t           state_reg,    state_next;
    logic [DIV_W-1:0] count_reg,    count_next;
    logic [DIV_W-1:0] cur_div_reg,  cur_div_next;
    logic [DIV_W-1:0] pend_div_reg, pend_div_next;
    logic             clk_en_reg,   clk_en_next;
    logic             tick_reg,     tick_next;
    logic             cfg_err_reg,  cfg_err_next;

    // Decoded helpers
    logic             ready_int;
    logic             offer_zero;
    logic             accept;
    logic             reject;
    logic             at_wrap;
    logic             at_start;
    logic             period_en;
    logic [DIV_W-1:0] half_div;
    logic [DIV_W-1:0] count_step;

    // ready depends on state only; PEND holds off new factors until the
    // pending one has been applied at the boundary.
    assign ready_int  = (state_reg != ST_PEND);
    assign offer_zero = (cfg_div == DIV_ZERO);
    assign accept     = cfg_valid & ready_int & ~offer_zero;
    assign reject     = cfg_valid & ready_int &  offer_zero;

    // Counter decode, all from current register values
    assign at_wrap    = (count_reg == (cur_div_reg - DIV_ONE));
    assign at_start   = (count_reg == DIV_ZERO);
    assign half_div   = cur_div_reg >> 1;
    // N=1 would give floor(1/2)=0 high counts; it is defined as constant high
    assign period_en  = (cur_div_reg == DIV_ONE) ? 1'b1 : (count_reg < half_div);
    assign count_step = at_wrap ? DIV_ZERO : (count_reg + DIV_ONE);

    // Next-state and next-output logic for the STOP/RUN/PEND controller
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        cur_div_next  = cur_div_reg;
        pend_div_next = pend_div_reg;
        clk_en_next   = 1'b0;
        tick_next     = 1'b0;
        cfg_err_next  = reject;

        case (state_reg)
            ST_STOP: begin
                // Stopped: nothing to protect, so a new factor loads directly
                count_next = DIV_ZERO;
                if (accept) begin
                    cur_div_next = cfg_div;
                end
                if (enable) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!enable) begin
                    // Stopping ends the period, so a factor offered on the
                    // same edge may take effect immediately
                    state_next = ST_STOP;
                    count_next = DIV_ZERO;
                    if (accept) begin
                        cur_div_next = cfg_div;
                    end
                end else begin
                    clk_en_next = period_en;
                    tick_next   = at_start;
                    count_next  = count_step;
                    // Accepted on a wrap edge it is still only parked here;
                    // it is applied at the following boundary
                    if (accept) begin
                        pend_div_next = cfg_div;
                        state_next    = ST_PEND;
                    end
                end
            end

            ST_PEND: begin
                if (!enable) begin
                    // Commit the parked factor as we stop
                    state_next   = ST_STOP;
                    count_next   = DIV_ZERO;
                    cur_div_next = pend_div_reg;
                end else begin
                    // Outputs for the boundary edge still use the old factor
                    clk_en_next = period_en;
                    tick_next   = at_start;
                    count_next  = count_step;
                    if (at_wrap) begin
                        cur_div_next = pend_div_reg;
                        count_next   = DIV_ZERO;
                        state_next   = ST_RUN;
                    end
                end
            end

            default: begin
                state_next = ST_STOP;
                count_next = DIV_ZERO;
            end
        endcase
    end

    // State and output registers; reset restores the default factor and
    // discards any pending one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_STOP;
            count_reg    <= DIV_ZERO;
            cur_div_reg  <= DIV_RESET;
            pend_div_reg <= DIV_ZERO;
            clk_en_reg   <= 1'b0;
            tick_reg     <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            cur_div_reg  <= cur_div_next;
            pend_div_reg <= pend_div_next;
            clk_en_reg   <= clk_en_next;
            tick_reg     <= tick_next;
            cfg_err_reg  <= cfg_err_next;
        end
    end

    assign cfg_ready = ready_int;
    assign cfg_err   = cfg_err_reg;
    assign clk_en    = clk_en_reg;
    assign tick      = tick_reg;
    assign cur_div   = cur_div_reg;
    assign running   = (state_reg == ST_RUN) || (state_reg == ST_PEND);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl with hand-computed
// expectations. Edges are numbered from the edge that takes the controller
// from STOP into RUN (edge 0); outputs are sampled 1 ns after each edge.
module tb_clk_div_ctrl;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_en;
    logic       tick;
    logic [7:0] cur_div;
    logic       running;

    int n_tests;
    int n_fail;

    clk_div_ctrl #(
        .DIV_W       (8),
        .DEFAULT_DIV (10)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_en    (clk_en),
        .tick      (tick),
        .cur_div   (cur_div),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic exp_en, input logic exp_tick);
        chk({tag, ".clk_en"}, 32'(clk_en), 32'(exp_en));
        chk({tag, ".tick"},   32'(tick),   32'(exp_tick));
    endtask

    initial begin
        int m;
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // ---- reset values ----
        #1 rstn = 1'b0;
        #2;
        chk("rst.clk_en",    32'(clk_en),    32'd0);
        chk("rst.tick",      32'(tick),      32'd0);
        chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst.cfg_err",   32'(cfg_err),   32'd0);
        chk("rst.cur_div",   32'(cur_div),   32'd10);
        chk("rst.running",   32'(running),   32'd0);
        step();
        step();
        rstn   = 1'b1;
        enable = 1'b1;

        // ---- default N=10: 5 high / 5 low, tick at edges 1, 11, 21 ----
        step(); // edge 0
        chk("e0.running", 32'(running), 32'd1);
        chk_out("e0", 1'b0, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            step();
            chk_out($sformatf("n10_e%0d", k), ((k - 1) % 10) < 5, ((k - 1) % 10) == 0);
        end
        chk("n10.cur_div", 32'(cur_div), 32'd10);

        // ---- offer 4 at count=3; applied at the wrap edge 30 ----
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        step(); // edge 24
        chk_out("acc4_e24", 1'b1, 1'b0);
        chk("acc4_e24.cfg_ready", 32'(cfg_ready), 32'd0);
        chk("acc4_e24.cur_div",   32'(cur_div),   32'd10);
        cfg_div = 8'd9; // offer side changes while not ready; must be ignored
        for (int k = 25; k <= 29; k++) begin
            step();
            chk_out($sformatf("pend4_e%0d", k), ((k - 1) % 10) < 5, 1'b0);
            chk($sformatf("pend4_e%0d.cfg_ready", k), 32'(cfg_ready), 32'd0);
            chk($sformatf("pend4_e%0d.cur_div", k),   32'(cur_div),   32'd10);
        end
        step(); // edge 30: wrap, apply
        chk_out("wrap4_e30", 1'b0, 1'b0);
        chk("wrap4_e30.cur_div",   32'(cur_div),   32'd4);
        chk("wrap4_e30.cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b0;
        for (int k = 31; k <= 38; k++) begin
            step();
            m = (k - 31) % 4;
            chk_out($sformatf("n4_e%0d", k), m < 2, m == 0);
        end

        // ---- offer 1 while N=4; applied at wrap edge 42 ----
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        step(); // edge 39
        chk_out("acc1_e39", 1'b1, 1'b1);
        chk("acc1_e39.cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        for (int k = 40; k <= 42; k++) begin
            step();
            m = (k - 31) % 4;
            chk_out($sformatf("pend1_e%0d", k), m < 2, m == 0);
            chk($sformatf("pend1_e%0d.cur_div", k), 32'(cur_div), (k == 42) ? 32'd1 : 32'd4);
        end
        chk("apply1.cfg_ready", 32'(cfg_ready), 32'd1);
        for (int k = 43; k <= 46; k++) begin
            step();
            chk_out($sformatf("n1_e%0d", k), 1'b1, 1'b1);
        end

        // ---- offer 3 while N=1; applied on the next edge ----
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        step(); // edge 47
        chk_out("acc3_e47", 1'b1, 1'b1);
        chk("acc3_e47.cur_div",   32'(cur_div),   32'd1);
        chk("acc3_e47.cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        step(); // edge 48
        chk_out("apply3_e48", 1'b1, 1'b1);
        chk("apply3_e48.cur_div",   32'(cur_div),   32'd3);
        chk("apply3_e48.cfg_ready", 32'(cfg_ready), 32'd1);
        for (int k = 49; k <= 54; k++) begin
            step();
            m = (k - 49) % 3;
            chk_out($sformatf("n3_e%0d", k), m == 0, m == 0);
        end

        // ---- zero factor rejected: one-cycle cfg_err ----
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        step(); // edge 55
        chk_out("zero_e55", 1'b1, 1'b1);
        chk("zero_e55.cfg_err",   32'(cfg_err),   32'd1);
        chk("zero_e55.cfg_ready", 32'(cfg_ready), 32'd1);
        chk("zero_e55.cur_div",   32'(cur_div),   32'd3);
        cfg_valid = 1'b0;
        step(); // edge 56
        chk_out("zero_e56", 1'b0, 1'b0);
        chk("zero_e56.cfg_err", 32'(cfg_err), 32'd0);
        chk("zero_e56.cur_div", 32'(cur_div), 32'd3);
        step(); // edge 57
        chk_out("zero_e57", 1'b0, 1'b0);

        // ---- accept 6 (PEND), then stop before wrap ----
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        step(); // edge 58
        chk_out("acc6_e58", 1'b1, 1'b1);
        chk("acc6_e58.cfg_ready", 32'(cfg_ready), 32'd0);
        chk("acc6_e58.cur_div",   32'(cur_div),   32'd3);
        cfg_valid = 1'b0;
        enable    = 1'b0;
        step(); // edge 59
        chk_out("stop_e59", 1'b0, 1'b0);
        chk("stop_e59.running",   32'(running),   32'd0);
        chk("stop_e59.cur_div",   32'(cur_div),   32'd6);
        chk("stop_e59.cfg_ready", 32'(cfg_ready), 32'd1);
        step(); // edge 60
        chk("stop_e60.running", 32'(running), 32'd0);
        chk_out("stop_e60", 1'b0, 1'b0);
        enable = 1'b1;
        step(); // edge 61
        chk("run_e61.running", 32'(running), 32'd1);
        chk_out("run_e61", 1'b0, 1'b0);
        for (int k = 62; k <= 73; k++) begin
            step();
            m = (k - 62) % 6;
            chk_out($sformatf("n6_e%0d", k), m < 3, m == 0);
        end

        // ---- async reset mid-PEND with 7 pending ----
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        step(); // edge 74
        chk_out("acc7_e74", 1'b1, 1'b1);
        chk("acc7_e74.cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        chk("arst.clk_en",    32'(clk_en),    32'd0);
        chk("arst.tick",      32'(tick),      32'd0);
        chk("arst.cur_div",   32'(cur_div),   32'd10);
        chk("arst.running",   32'(running),   32'd0);
        chk("arst.cfg_ready", 32'(cfg_ready), 32'd1);
        step();
        step();
        rstn = 1'b1;
        step(); // STOP -> RUN
        chk("rel.running", 32'(running), 32'd1);
        chk("rel.cur_div", 32'(cur_div), 32'd10);
        chk_out("rel", 1'b0, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            step();
            m = (j - 1) % 10;
            chk_out($sformatf("rel_n10_%0d", j), m < 5, m == 0);
            chk($sformatf("rel_n10_%0d.cur_div", j), 32'(cur_div), 32'd10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time controller for the clock-enable divider function: holds the active divide factor and sequences the divide counter.
- Emits the divided enable and a period-start tick.
- Accepts new divide factors over a valid/ready handshake and applies them only at a period boundary, so no runt or stretched period ever appears on clk_en.
- Sits between the register/config interface and every downstream block gated by clk_en.

Parameters:
DIV_W, 8, width of divide-factor fields; legal factors 1..2^DIV_W-1
DEFAULT_DIV, 10, divide factor loaded at reset; must be 1..2^DIV_W-1

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
enable  input  1  run request; low stops the divider synchronously
cfg_valid  input  1  new divide factor offered
cfg_div  input  DIV_W  offered divide factor
cfg_ready  output  1  controller can accept a factor this cycle
cfg_err  output  1  one-cycle pulse: offered factor was 0 and was rejected
clk_en  output  1  divided enable; high for first floor(N/2) counts of each N-cycle period (N=1: constant high)
tick  output  1  one-cycle pulse on the first cycle of each period
cur_div  output  DIV_W  divide factor currently in effect
running  output  1  high in RUN or PEND

Behaviour:
- Reset (rstn low, asynchronous), values while rstn is low:
  - state=STOP, count=0, cur_div=DEFAULT_DIV, pend_div=0
  - clk_en=0, tick=0, cfg_ready=1, cfg_err=0
- Internal counter: count, DIV_W bits, range 0..cur_div-1.
- States: STOP, RUN, PEND (RUN with an update pending). running=1 in RUN and PEND.
- STOP:
  - count=0, clk_en<=0, tick<=0.
  - enable=1 -> RUN at next edge.
  - An accepted cfg loads cur_div directly at the accepting edge.
- RUN/PEND, each edge, evaluated from current values:
  - clk_en <= 1 if cur_div==1, else (count < cur_div>>1)
  - tick <= (count==0)
  - count <= (count==cur_div-1) ? 0 : count+1
- Resulting waveforms (one-cycle register latency from enable to first clk_en/tick):
  - N=10: 5 high, 5 low.
  - N=3: 1 high, 2 low.
  - N=2: 1 high, 1 low.
  - N=1: clk_en and tick constant 1.
- Handshake:
  - Accept = cfg_valid & cfg_ready & (cfg_div!=0).
  - cfg_ready=1 in STOP and RUN, 0 in PEND.
  - In RUN, an accept stores pend_div and moves to PEND.
  - The offer-side value may change freely while cfg_ready=0.
- Boundary apply:
  - In PEND, at the edge where count==cur_div-1: cur_div<=pend_div, count<=0, state->RUN.
  - clk_en/tick for that edge are still computed from the old factor.
  - The next period runs entirely with the new factor.
- Same-edge accept and wrap: a factor accepted in RUN on the wrap edge is NOT applied at that wrap; it is applied at the following boundary (for N=1, the next edge).
- cfg_div==0 with cfg_valid & cfg_ready:
  - Not accepted; cur_div and state unchanged.
  - cfg_err=1 for exactly the next cycle.
  - cfg_ready stays 1.
- enable low in RUN/PEND:
  - Next edge -> STOP, count=0, clk_en=0, tick=0.
  - A pending factor is committed to cur_div at that same edge; cfg_ready=1 afterwards.
- enable low and cfg accept on the same edge in STOP: cur_div loads; state stays STOP.
- Reset mid-period or mid-PEND discards pend_div and restores DEFAULT_DIV.
- No combinational path from inputs to any output except cfg_ready, which depends only on state.

Test Plan:
- Reset release, enable=1 at cycle 0, DEFAULT_DIV=10 -> clk_en first high at cycle 1, pattern 5 high / 5 low repeating; tick at cycles 1, 11, 21; cur_div=10.
- Running N=10, offer cfg_div=4 at count=3 -> cfg_ready drops for one cycle after acceptance and stays low until wrap; first 10-period completes intact; following periods 2 high / 2 low; cur_div changes to 4 exactly at the wrap edge.
- Offer cfg_div=1 while running N=4 -> after boundary, clk_en and tick held 1 every cycle; then offer 3 -> applied on the next edge; pattern 1 high / 2 low.
- Offer cfg_div=0 in RUN -> cfg_err pulses exactly 1 cycle; cur_div, clk_en pattern and cfg_ready unchanged.
- Accept cfg_div=6 (PEND), then drop enable before wrap -> next edge clk_en=0, running=0, cur_div=6, cfg_ready=1; re-enable -> 3 high / 3 low.
- Assert rstn low asynchronously mid-PEND with pending 7 -> outputs go to reset values immediately; cur_div=10 after release; pending 7 never appears.
